// File: rtl/dsi_lane_pkg.sv
// ---------------------------------------------------------------------------
// dsi_lane_pkg
//   Shared definitions for the DSI lane distributor:
//     - lane_state_t  : distributor FSM states (IDLE, FILL, SEND, DONE)
//     - MAX_LANES_DEF : default number of physical PPI data lanes
//     - lane_mask()   : n -> mask with the n low bits set (n = 0..4)
// ---------------------------------------------------------------------------
package dsi_lane_pkg;

    localparam int MAX_LANES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } lane_state_t;

    // Thermometer mask: lanes 0..n-1 enabled.
    function automatic logic [MAX_LANES_DEF-1:0] lane_mask(input logic [2:0] n);
        logic [MAX_LANES_DEF-1:0] m;
        for (int i = 0; i < MAX_LANES_DEF; i++) begin
            m[i] = (3'(i) < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/lane_distributor.sv
// ---------------------------------------------------------------------------
// lane_distributor
//   Spreads a DSI packet byte stream across 1..MAX_LANES PPI data lanes.
//   Bytes are gathered into a slot register (one slot per lane); once a
//   beat is full, or the packet ends, the beat is presented to the PHY.
//
// Handshakes (both sides use the same rule):
//   A transfer happens on a rising dsi_clk edge where valid && ready are
//   both high. The producer holds its data stable while valid is high and
//   ready is low; ready never depends combinationally on valid.
//
// Ports
//   dsi_clk, dsi_rst_n : clock, asynchronous active-low reset
//   cfg_lanes          : active lanes minus one, sampled at SOP acceptance
//   in_data/in_valid/in_sop/in_eop/in_ready : byte stream input
//   ppi_data           : lane k on bits [8k+7:8k]
//   ppi_valid/ppi_ready: beat handshake with the PHY (TxReady)
//   ppi_lane_en        : per-lane HS request
//   lane_done          : one-cycle pulse after the final beat
//   err_proto          : one-cycle pulse on a framing violation
//   pkt_len            : bytes delivered in the last completed packet
//   dbg_state          : current FSM state (lane_state_t encoding)
// ---------------------------------------------------------------------------
module lane_distributor
    import dsi_lane_pkg::*;
#(
    parameter int MAX_LANES = MAX_LANES_DEF,  // legal range 1..4
    parameter int LEN_W     = 16
) (
    input  logic                   dsi_clk,
    input  logic                   dsi_rst_n,
    input  logic [1:0]             cfg_lanes,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    input  logic                   in_sop,
    input  logic                   in_eop,
    output logic                   in_ready,
    output logic [MAX_LANES*8-1:0] ppi_data,
    output logic                   ppi_valid,
    input  logic                   ppi_ready,
    output logic [MAX_LANES-1:0]   ppi_lane_en,
    output logic                   lane_done,
    output logic                   err_proto,
    output logic [LEN_W-1:0]       pkt_len,
    output logic [1:0]             dbg_state
);

    lane_state_t      state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;        // slots filled in the current beat
    logic [2:0]       lanes_q, lanes_d;    // lanes latched at SOP
    logic             final_q, final_d;    // current beat holds the EOP byte
    logic [7:0]       slot_q [MAX_LANES];
    logic [7:0]       slot_d [MAX_LANES];
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
    logic             err_q, err_d;
    // Holds in_ready low while reset is asserted and releases it on the
    // first clock edge afterwards.
    logic             rdy_en_q, rdy_en_d;

    logic                     accept;
    logic [2:0]               cfg_n;
    logic [2:0]               lanes_sel;
    logic [LEN_W-1:0]         byte_inc;
    logic [MAX_LANES_DEF-1:0] en_mask;

    // Requested lane count, clamped to the lanes physically present.
    assign cfg_n     = {1'b0, cfg_lanes} + 3'd1;
    assign lanes_sel = (cfg_n > 3'(MAX_LANES)) ? 3'(MAX_LANES) : cfg_n;

    // Byte counter saturates at all ones instead of wrapping.
    assign byte_inc = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + LEN_W'(1);

    assign in_ready = rdy_en_q && ((state_q == ST_IDLE) || (state_q == ST_FILL));
    assign accept   = in_valid && in_ready;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lanes_d    = lanes_q;
        final_d    = final_q;
        slot_d     = slot_q;
        byte_cnt_d = byte_cnt_q;
        pkt_len_d  = pkt_len_q;
        err_d      = 1'b0;
        rdy_en_d   = 1'b1;

        if (accept) begin
            if (in_sop) begin
                // Start of packet. In FILL this abandons the partial packet.
                if (state_q == ST_FILL) begin
                    err_d = 1'b1;
                end
                lanes_d = lanes_sel;
                for (int k = 0; k < MAX_LANES; k++) begin
                    slot_d[k] = 8'h00;
                end
                slot_d[0]  = in_data;
                cnt_d      = 3'd1;
                byte_cnt_d = LEN_W'(1);
                final_d    = in_eop;
                // A single-lane beat is already full after the first byte.
                if (in_eop || (lanes_sel == 3'd1)) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_FILL;
                end
            end else if (state_q == ST_IDLE) begin
                // Byte outside any packet: dropped.
                err_d = 1'b1;
            end else begin
                for (int k = 0; k < MAX_LANES; k++) begin
                    if (3'(k) == cnt_q) begin
                        slot_d[k] = in_data;
                    end
                end
                cnt_d      = cnt_q + 3'd1;
                byte_cnt_d = byte_inc;
                final_d    = in_eop;
                if (in_eop || ((cnt_q + 3'd1) == lanes_q)) begin
                    state_d = ST_SEND;
                end
            end
        end

        case (state_q)
            ST_SEND: begin
                if (ppi_ready) begin
                    for (int k = 0; k < MAX_LANES; k++) begin
                        slot_d[k] = 8'h00;
                    end
                    cnt_d = 3'd0;
                    if (final_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_DONE: begin
                pkt_len_d = byte_cnt_q;
                final_d   = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        en_mask = '0;
        case (state_q)
            ST_FILL: en_mask = lane_mask(lanes_q);
            // On the final beat only lanes that actually carry data keep HS.
            ST_SEND: en_mask = final_q ? lane_mask(cnt_q) : lane_mask(lanes_q);
            default: en_mask = '0;
        endcase
    end

    always_comb begin
        ppi_data = '0;
        for (int k = 0; k < MAX_LANES; k++) begin
            ppi_data[8*k +: 8] = slot_q[k];
        end
    end

    assign ppi_lane_en = en_mask[MAX_LANES-1:0];
    assign ppi_valid   = (state_q == ST_SEND);
    assign lane_done   = (state_q == ST_DONE);
    assign err_proto   = err_q;
    assign pkt_len     = pkt_len_q;
    assign dbg_state   = state_q;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge dsi_clk or negedge dsi_rst_n) begin
        if (!dsi_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            lanes_q    <= 3'd1;
            final_q    <= 1'b0;
            for (int k = 0; k < MAX_LANES; k++) begin
                slot_q[k] <= 8'h00;
            end
            byte_cnt_q <= '0;
            pkt_len_q  <= '0;
            err_q      <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lanes_q    <= lanes_d;
            final_q    <= final_d;
            for (int k = 0; k < MAX_LANES; k++) begin
                slot_q[k] <= slot_d[k];
            end
            byte_cnt_q <= byte_cnt_d;
            pkt_len_q  <= pkt_len_d;
            err_q      <= err_d;
            rdy_en_q   <= rdy_en_d;
        end
    end

endmodule

// File: tb/tb_lane_distributor.sv
// ---------------------------------------------------------------------------
// tb_lane_distributor
//   Drives packets into lane_distributor (4 lanes) and a second instance
//   built with MAX_LANES=2, LEN_W=3. Expected beats come from a chunking
//   model of the packet byte list; a negedge monitor collects what the DUT
//   actually transferred.
// ---------------------------------------------------------------------------
module tb_lane_distributor;
    import dsi_lane_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- DUT (4 lanes) ----------------
    logic [1:0]  cfg_lanes;
    logic [7:0]  in_data;
    logic        in_valid, in_sop, in_eop;
    logic        in_ready;
    logic [31:0] ppi_data;
    logic        ppi_valid;
    logic        ppi_ready;
    logic [3:0]  ppi_lane_en;
    logic        lane_done, err_proto;
    logic [15:0] pkt_len;
    logic [1:0]  dbg_state;

    lane_distributor #(.MAX_LANES(4), .LEN_W(16)) dut (
        .dsi_clk(clk), .dsi_rst_n(rst_n), .cfg_lanes(cfg_lanes),
        .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_ready(in_ready), .ppi_data(ppi_data), .ppi_valid(ppi_valid),
        .ppi_ready(ppi_ready), .ppi_lane_en(ppi_lane_en), .lane_done(lane_done),
        .err_proto(err_proto), .pkt_len(pkt_len), .dbg_state(dbg_state)
    );

    // ---------------- DUT2 (2 lanes, 3-bit length) ----------------
    logic [1:0]  d2_cfg;
    logic [7:0]  d2_data;
    logic        d2_valid, d2_sop, d2_eop;
    logic        d2_ready;
    logic [15:0] d2_ppi_data;
    logic        d2_ppi_valid;
    logic [1:0]  d2_lane_en;
    logic        d2_done, d2_err;
    logic [2:0]  d2_pkt_len;
    logic [1:0]  d2_dbg;

    lane_distributor #(.MAX_LANES(2), .LEN_W(3)) dut2 (
        .dsi_clk(clk), .dsi_rst_n(rst_n), .cfg_lanes(d2_cfg),
        .in_data(d2_data), .in_valid(d2_valid), .in_sop(d2_sop), .in_eop(d2_eop),
        .in_ready(d2_ready), .ppi_data(d2_ppi_data), .ppi_valid(d2_ppi_valid),
        .ppi_ready(1'b1), .ppi_lane_en(d2_lane_en), .lane_done(d2_done),
        .err_proto(d2_err), .pkt_len(d2_pkt_len), .dbg_state(d2_dbg)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    // PHY ready pattern: 0 = always ready, 1 = random, 2 = held low
    int rdy_mode = 0;
    initial begin
        ppi_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) ppi_ready = ($urandom_range(0, 9) < 7);
            else               ppi_ready = (rdy_mode == 0);
        end
    end

    // ---------------- monitors ----------------
    logic [31:0] obs_q[$];
    logic [3:0]  obs_en_q[$];
    int          obs_t_q[$];
    int          done_cnt = 0;
    int          done_t   = 0;
    int          err_cnt  = 0;
    int          neg_cnt  = 0;
    logic [15:0] d2_obs_q[$];
    logic [1:0]  d2_en_q[$];
    int          d2_done_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ppi_valid && ppi_ready) begin
                obs_q.push_back(ppi_data);
                obs_en_q.push_back(ppi_lane_en);
                obs_t_q.push_back(neg_cnt);
            end
            if (lane_done) begin
                done_cnt++;
                done_t = neg_cnt;
            end
            if (err_proto) err_cnt++;
            if (d2_ppi_valid) begin
                d2_obs_q.push_back(d2_ppi_data);
                d2_en_q.push_back(d2_lane_en);
            end
            if (d2_done) d2_done_cnt++;
        end
        neg_cnt++;
    end

    // ---------------- reference model ----------------
    logic [7:0]  pkt_q[$];
    logic [31:0] exp_q[$];
    logic [3:0]  exp_en_q[$];

    // Beat i carries bytes i*n .. i*n+n-1, byte j of the beat on lane j;
    // missing bytes read as zero. Every beat requests n lanes except the
    // last, which requests only the lanes that received a byte.
    function automatic void model_beats(input int n);
        exp_q.delete();
        exp_en_q.delete();
        for (int i = 0; i < pkt_q.size(); i += n) begin
            logic [31:0] w;
            int c;
            w = '0;
            c = 0;
            for (int j = 0; j < n && (i + j) < pkt_q.size(); j++) begin
                w[8*j +: 8] = pkt_q[i + j];
                c++;
            end
            exp_q.push_back(w);
            if (i + n >= pkt_q.size()) exp_en_q.push_back(4'((1 << c) - 1));
            else                       exp_en_q.push_back(4'((1 << n) - 1));
        end
    endfunction

    function automatic void make_pkt(input int len, input logic [7:0] first, input bit rnd);
        pkt_q.delete();
        for (int i = 0; i < len; i++) begin
            if (rnd) pkt_q.push_back(8'($urandom_range(0, 255)));
            else     pkt_q.push_back(first + 8'(i));
        end
    endfunction

    // ---------------- driver tasks (phase: posedge + 2) ----------------
    task automatic send_pkt(input int gap_max, input bit with_eop, input int cfg_after,
                            output bit to);
        int guard;
        to = 1'b0;
        for (int i = 0; i < pkt_q.size(); i++) begin
            if (gap_max > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #2; end
            end
            in_data  = pkt_q[i];
            in_sop   = (i == 0);
            in_eop   = with_eop && (i == pkt_q.size() - 1);
            in_valid = 1'b1;
            guard = 0;
            while (!in_ready && guard < 300) begin @(posedge clk); #2; guard++; end
            if (guard >= 300) begin
                to = 1'b1;
                break;
            end
            @(posedge clk); #2;
            if (i == 0 && cfg_after >= 0) cfg_lanes = 2'(cfg_after);
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic wait_done(input int prev, output bit to);
        int guard;
        guard = 0;
        while (done_cnt == prev && guard < 3000) begin @(posedge clk); #2; guard++; end
        to = (done_cnt == prev);
    endtask

    task automatic send_pkt2(output bit to);
        int guard;
        int prev;
        to   = 1'b0;
        prev = d2_done_cnt;
        for (int i = 0; i < pkt_q.size(); i++) begin
            d2_data  = pkt_q[i];
            d2_sop   = (i == 0);
            d2_eop   = (i == pkt_q.size() - 1);
            d2_valid = 1'b1;
            guard = 0;
            while (!d2_ready && guard < 300) begin @(posedge clk); #2; guard++; end
            if (guard >= 300) to = 1'b1;
            @(posedge clk); #2;
        end
        d2_valid = 1'b0;
        d2_sop   = 1'b0;
        d2_eop   = 1'b0;
        guard = 0;
        while (d2_done_cnt == prev && guard < 300) begin @(posedge clk); #2; guard++; end
        if (d2_done_cnt == prev) to = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if ({ppi_valid, ppi_lane_en, lane_done, err_proto, in_ready} !== 8'h00)
            $display("FAIL reset_outputs: got %b, expected 00000000",
                     {ppi_valid, ppi_lane_en, lane_done, err_proto, in_ready});
        else n_pass++;
        n_checks++;
        if (pkt_len !== 16'h0 || dbg_state !== 2'(ST_IDLE))
            $display("FAIL reset_state: got pkt_len=%h state=%0d, expected 0/%0d",
                     pkt_len, dbg_state, ST_IDLE);
        else n_pass++;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_ready_hold: got %b, expected 0", in_ready);
        else n_pass++;
        @(posedge clk); #2;
        n_checks++;
        if (in_ready !== 1'b1 || d2_ready !== 1'b1)
            $display("FAIL reset_ready_rise: got %b/%b, expected 1/1", in_ready, d2_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        int base, prev;
        bit to;
        cfg_lanes = 2'd3;
        rdy_mode  = 0;
        make_pkt(12, 8'h01, 1'b0);
        model_beats(4);
        base = obs_q.size();
        prev = done_cnt;
        send_pkt(0, 1'b1, -1, to);
        wait_done(prev, to);
        n_checks++;
        if (to) $display("FAIL basic_timeout: got no lane_done, expected one");
        else n_pass++;
        n_checks++;
        if (obs_q.size() - base !== exp_q.size())
            $display("FAIL basic_count: got %0d beats, expected %0d", obs_q.size() - base, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[base+i] !== exp_q[i] || obs_en_q[base+i] !== exp_en_q[i])
                $display("FAIL basic_beat%0d: got %h/%h, expected %h/%h", i,
                         obs_q[base+i], obs_en_q[base+i], exp_q[i], exp_en_q[i]);
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (obs_t_q[base+i] - obs_t_q[base+i-1] !== 5)
                    $display("FAIL basic_spacing%0d: got %0d cycles, expected 5", i,
                             obs_t_q[base+i] - obs_t_q[base+i-1]);
                else n_pass++;
            end
        end
        if (obs_q.size() > base) begin
            n_checks++;
            if (done_t - obs_t_q[obs_t_q.size()-1] !== 1)
                $display("FAIL basic_done_lat: got %0d, expected 1", done_t - obs_t_q[obs_t_q.size()-1]);
            else n_pass++;
        end
        n_checks++;
        if (pkt_len !== 16'd12) $display("FAIL basic_pkt_len: got %0d, expected 12", pkt_len);
        else n_pass++;
        repeat (3) begin @(posedge clk); #2; end
        n_checks++;
        if (done_cnt !== prev + 1) $display("FAIL basic_done_width: got %0d pulses, expected 1", done_cnt - prev);
        else n_pass++;
    endtask

    task automatic test_two_lane();
        int base, prev;
        bit to;
        cfg_lanes = 2'd1;
        make_pkt(5, 8'hA0, 1'b0);
        model_beats(2);
        base = obs_q.size();
        prev = done_cnt;
        send_pkt(0, 1'b1, -1, to);
        wait_done(prev, to);
        n_checks++;
        if (to || obs_q.size() - base !== exp_q.size())
            $display("FAIL two_lane_count: got %0d beats (timeout=%b), expected %0d",
                     obs_q.size() - base, to, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[base+i] !== exp_q[i] || obs_en_q[base+i] !== exp_en_q[i])
                $display("FAIL two_lane_beat%0d: got %h/%h, expected %h/%h", i,
                         obs_q[base+i], obs_en_q[base+i], exp_q[i], exp_en_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (pkt_len !== 16'd5) $display("FAIL two_lane_pkt_len: got %0d, expected 5", pkt_len);
        else n_pass++;
    endtask

    task automatic test_stall();
        int base, prev, guard;
        bit to, stall_to;
        logic [31:0] held;
        cfg_lanes = 2'd3;
        rdy_mode  = 0;
        make_pkt(12, 8'h00, 1'b1);
        model_beats(4);
        base = obs_q.size();
        prev = done_cnt;
        stall_to = 1'b0;
        fork
            send_pkt(0, 1'b1, -1, to);
            begin
                guard = 0;
                while (obs_q.size() < base + 1 && guard < 300) begin @(posedge clk); #2; guard++; end
                rdy_mode = 2;
                guard = 0;
                while (!ppi_valid && guard < 300) begin @(posedge clk); #2; guard++; end
                stall_to = (guard >= 300);
                held = ppi_data;
                n_checks++;
                if (held !== exp_q[1]) $display("FAIL stall_beat: got %h, expected %h", held, exp_q[1]);
                else n_pass++;
                repeat (5) begin
                    @(posedge clk); #2;
                    n_checks++;
                    if (ppi_valid !== 1'b1 || ppi_data !== held || in_ready !== 1'b0)
                        $display("FAIL stall_hold: got valid=%b data=%h ready=%b, expected 1/%h/0",
                                 ppi_valid, ppi_data, in_ready, held);
                    else n_pass++;
                end
                rdy_mode = 0;
            end
        join
        wait_done(prev, to);
        n_checks++;
        if (to || stall_to || obs_q.size() - base !== exp_q.size())
            $display("FAIL stall_count: got %0d beats (timeout=%b), expected %0d",
                     obs_q.size() - base, to | stall_to, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[base+i] !== exp_q[i] || obs_en_q[base+i] !== exp_en_q[i])
                $display("FAIL stall_beat%0d: got %h/%h, expected %h/%h", i,
                         obs_q[base+i], obs_en_q[base+i], exp_q[i], exp_en_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_sop_restart();
        int base, prev, perr;
        bit to;
        cfg_lanes = 2'd3;
        base = obs_q.size();
        prev = done_cnt;
        perr = err_cnt;
        make_pkt(3, 8'h50, 1'b0);
        send_pkt(0, 1'b0, -1, to);
        make_pkt(6, 8'h60, 1'b0);
        model_beats(4);
        send_pkt(0, 1'b1, -1, to);
        wait_done(prev, to);
        n_checks++;
        if (err_cnt !== perr + 1) $display("FAIL sop_restart_err: got %0d pulses, expected 1", err_cnt - perr);
        else n_pass++;
        n_checks++;
        if (to || obs_q.size() - base !== exp_q.size())
            $display("FAIL sop_restart_count: got %0d beats (timeout=%b), expected %0d",
                     obs_q.size() - base, to, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[base+i] !== exp_q[i] || obs_en_q[base+i] !== exp_en_q[i])
                $display("FAIL sop_restart_beat%0d: got %h/%h, expected %h/%h", i,
                         obs_q[base+i], obs_en_q[base+i], exp_q[i], exp_en_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (pkt_len !== 16'd6) $display("FAIL sop_restart_pkt_len: got %0d, expected 6", pkt_len);
        else n_pass++;
    endtask

    task automatic test_stray_byte();
        int base, prev, perr, guard;
        base = obs_q.size();
        prev = done_cnt;
        perr = err_cnt;
        in_data  = 8'h77;
        in_sop   = 1'b0;
        in_eop   = 1'b1;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin @(posedge clk); #2; guard++; end
        @(posedge clk); #2;
        in_valid = 1'b0;
        in_eop   = 1'b0;
        repeat (4) begin @(posedge clk); #2; end
        n_checks++;
        if (err_cnt !== perr + 1 || obs_q.size() !== base || done_cnt !== prev)
            $display("FAIL stray_byte: got err=%0d beats=%0d done=%0d, expected 1/0/0",
                     err_cnt - perr, obs_q.size() - base, done_cnt - prev);
        else n_pass++;
    endtask

    task automatic test_cfg_mid_packet();
        int base, prev;
        bit to;
        cfg_lanes = 2'd1;
        make_pkt(7, 8'h00, 1'b1);
        model_beats(2);
        base = obs_q.size();
        prev = done_cnt;
        send_pkt(0, 1'b1, 3, to);
        wait_done(prev, to);
        n_checks++;
        if (to || obs_q.size() - base !== exp_q.size())
            $display("FAIL cfg_mid_count: got %0d beats (timeout=%b), expected %0d",
                     obs_q.size() - base, to, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[base+i] !== exp_q[i] || obs_en_q[base+i] !== exp_en_q[i])
                $display("FAIL cfg_mid_beat%0d: got %h/%h, expected %h/%h", i,
                         obs_q[base+i], obs_en_q[base+i], exp_q[i], exp_en_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int base, prev, perr, n, len;
        bit to;
        perr = err_cnt;
        for (int p = 0; p < 12; p++) begin
            cfg_lanes = 2'($urandom_range(0, 3));
            n         = int'(cfg_lanes) + 1;
            len       = $urandom_range(1, 17);
            rdy_mode  = $urandom_range(0, 1);
            make_pkt(len, 8'h00, 1'b1);
            model_beats(n);
            base = obs_q.size();
            prev = done_cnt;
            send_pkt($urandom_range(0, 2), 1'b1, -1, to);
            wait_done(prev, to);
            n_checks++;
            if (to || obs_q.size() - base !== exp_q.size())
                $display("FAIL rand%0d_count: got %0d beats (timeout=%b), expected %0d",
                         p, obs_q.size() - base, to, exp_q.size());
            else n_pass++;
            for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
                n_checks++;
                if (obs_q[base+i] !== exp_q[i] || obs_en_q[base+i] !== exp_en_q[i])
                    $display("FAIL rand%0d_beat%0d: got %h/%h, expected %h/%h", p, i,
                             obs_q[base+i], obs_en_q[base+i], exp_q[i], exp_en_q[i]);
                else n_pass++;
            end
            n_checks++;
            if (pkt_len !== 16'(len)) $display("FAIL rand%0d_pkt_len: got %0d, expected %0d", p, pkt_len, len);
            else n_pass++;
        end
        rdy_mode = 0;
        n_checks++;
        if (err_cnt !== perr) $display("FAIL rand_err: got %0d pulses, expected 0", err_cnt - perr);
        else n_pass++;
    endtask

    task automatic test_reset_mid_send();
        int base, prev;
        bit to;
        cfg_lanes = 2'd3;
        rdy_mode  = 2;
        repeat (2) begin @(posedge clk); #2; end
        make_pkt(4, 8'h90, 1'b0);
        send_pkt(0, 1'b0, -1, to);
        n_checks++;
        if (ppi_valid !== 1'b1 || ppi_lane_en !== 4'hF)
            $display("FAIL rst_send_pre: got valid=%b en=%h, expected 1/f", ppi_valid, ppi_lane_en);
        else n_pass++;
        prev  = done_cnt;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ppi_valid, ppi_lane_en, lane_done, err_proto, in_ready} !== 8'h00 || pkt_len !== 16'h0)
            $display("FAIL rst_send_async: got %b pkt_len=%0d, expected 00000000/0",
                     {ppi_valid, ppi_lane_en, lane_done, err_proto, in_ready}, pkt_len);
        else n_pass++;
        repeat (2) @(posedge clk);
        #2;
        rst_n    = 1'b1;
        rdy_mode = 0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL rst_send_ready_hold: got %b, expected 0", in_ready);
        else n_pass++;
        @(posedge clk); #2;
        n_checks++;
        if (in_ready !== 1'b1 || done_cnt !== prev)
            $display("FAIL rst_send_after: got ready=%b done=%0d, expected 1/0", in_ready, done_cnt - prev);
        else n_pass++;
        cfg_lanes = 2'd2;
        make_pkt(6, 8'hC0, 1'b0);
        model_beats(3);
        base = obs_q.size();
        send_pkt(0, 1'b1, -1, to);
        wait_done(prev, to);
        n_checks++;
        if (to || obs_q.size() - base !== exp_q.size())
            $display("FAIL rst_send_next_count: got %0d beats (timeout=%b), expected %0d",
                     obs_q.size() - base, to, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[base+i] !== exp_q[i] || obs_en_q[base+i] !== exp_en_q[i])
                $display("FAIL rst_send_next_beat%0d: got %h/%h, expected %h/%h", i,
                         obs_q[base+i], obs_en_q[base+i], exp_q[i], exp_en_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (pkt_len !== 16'd6) $display("FAIL rst_send_pkt_len: got %0d, expected 6", pkt_len);
        else n_pass++;
    endtask

    task automatic test_clamp_sat();
        int base;
        bit to;
        d2_cfg = 2'd2;
        // 4 bytes at a requested 3 lanes, only 2 lanes present.
        make_pkt(4, 8'h30, 1'b0);
        model_beats(2);
        base = d2_obs_q.size();
        send_pkt2(to);
        n_checks++;
        if (to || d2_obs_q.size() - base !== exp_q.size())
            $display("FAIL clamp_count: got %0d beats (timeout=%b), expected %0d",
                     d2_obs_q.size() - base, to, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && base + i < d2_obs_q.size(); i++) begin
            n_checks++;
            if (d2_obs_q[base+i] !== exp_q[i][15:0] || d2_en_q[base+i] !== exp_en_q[i][1:0])
                $display("FAIL clamp_beat%0d: got %h/%h, expected %h/%h", i,
                         d2_obs_q[base+i], d2_en_q[base+i], exp_q[i][15:0], exp_en_q[i][1:0]);
            else n_pass++;
        end
        n_checks++;
        if (d2_pkt_len !== 3'd4) $display("FAIL clamp_pkt_len: got %0d, expected 4", d2_pkt_len);
        else n_pass++;
        // 10 bytes with a 3-bit length counter: length saturates at 7.
        make_pkt(10, 8'h00, 1'b1);
        model_beats(2);
        base = d2_obs_q.size();
        send_pkt2(to);
        n_checks++;
        if (to || d2_obs_q.size() - base !== exp_q.size())
            $display("FAIL sat_count: got %0d beats (timeout=%b), expected %0d",
                     d2_obs_q.size() - base, to, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && base + i < d2_obs_q.size(); i++) begin
            n_checks++;
            if (d2_obs_q[base+i] !== exp_q[i][15:0] || d2_en_q[base+i] !== exp_en_q[i][1:0])
                $display("FAIL sat_beat%0d: got %h/%h, expected %h/%h", i,
                         d2_obs_q[base+i], d2_en_q[base+i], exp_q[i][15:0], exp_en_q[i][1:0]);
            else n_pass++;
        end
        n_checks++;
        if (d2_pkt_len !== 3'd7) $display("FAIL sat_pkt_len: got %0d, expected 7", d2_pkt_len);
        else n_pass++;
    endtask

    // ---------------- sequence ----------------
    initial begin
        cfg_lanes = 2'd3;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        d2_cfg    = 2'd0;
        d2_data   = 8'h00;
        d2_valid  = 1'b0;
        d2_sop    = 1'b0;
        d2_eop    = 1'b0;
        test_reset();
        test_basic();
        test_two_lane();
        test_stall();
        test_sop_restart();
        test_stray_byte();
        test_cfg_mid_packet();
        test_random();
        test_reset_mid_send();
        test_clamp_sat();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
